// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg
//   Shared definitions for the layer sequencing controller:
//   FSM state encoding, default watchdog limit and a width helper.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_done_sequencer_if.sv
// layer_done_sequencer_if
//   Control/handshake bundle between the inference host, the neuron
//   units and the layer sequencer.
//   start       host -> seq   begin inference
//   unit_done   units -> seq  per-unit completion flags
//   unit_start  seq -> units  one-cycle launch pulse
//   layer_idx   seq -> units  layer launched / awaited
//   busy        seq -> host   inference in progress
//   done        seq -> host   one-cycle completion pulse
//   timeout_err seq -> host   sticky watchdog error
interface layer_done_sequencer_if #(
  parameter int NUM_UNITS = 4,
  parameter int LIDX_W    = 2
);
  logic                 start;
  logic [NUM_UNITS-1:0] unit_done;
  logic                 unit_start;
  logic [LIDX_W-1:0]    layer_idx;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;

  modport master (
    output start, unit_done,
    input  unit_start, layer_idx, busy, done, timeout_err
  );

  modport slave (
    input  start, unit_done,
    output unit_start, layer_idx, busy, done, timeout_err
  );
endinterface

// File: rtl/done_collector.sv
// done_collector
//   Sticky per-unit completion latches plus the AND reduction that forms
//   the layer-completion term.
//   CLOCK      system clock
//   RESET      synchronous active-high reset
//   clr        clear all latches
//   en         sample unit_done into the latches
//   unit_done  per-unit completion inputs
//   all_done   every unit latched or arriving this cycle
module done_collector #(
  parameter int NUM_UNITS = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 clr,
  input  logic                 en,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 all_done
);

  logic [NUM_UNITS-1:0] r_latch;

  always_ff @(posedge CLOCK) begin
    if (RESET)     r_latch <= '0;
    else if (clr)  r_latch <= '0;
    else if (en)   r_latch <= r_latch | unit_done;
  end

  // Same-cycle arrivals count, so the last unit need not wait a cycle.
  assign all_done = &(r_latch | unit_done);

endmodule

// File: rtl/layer_done_sequencer.sv
// layer_done_sequencer
//   Launches every layer of an inference, waits for all units to report
//   done, steps the layer index and pulses done after the last layer.
//   A watchdog traps a layer that never completes.
//   CLOCK  system clock
//   RESET  synchronous active-high reset
//   bus    slave side of layer_done_sequencer_if
//
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_LAUNCH  | unit_start pulse, latches and watchdog cleared
//   S_WAIT    | collecting unit_done, watchdog counting
//   S_ADVANCE | layer complete, step index or finish
//   S_FINISH  | done pulse
//   S_ERROR   | watchdog expired, held until reset
module layer_done_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int LIDX_W     = width_of(NUM_LAYERS)
) (
  input logic                   CLOCK,
  input logic                   RESET,
  layer_done_sequencer_if.slave bus
);

  localparam int CNT_W = width_of(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [LIDX_W-1:0] LAYER_LAST = LIDX_W'(NUM_LAYERS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LIDX_W-1:0]   r_layer_idx;
  logic [CNT_W-1:0]    r_wd_cnt;
  logic                w_all_done;
  logic                w_clr;
  logic                w_en;

  assign w_en  = (r_state == S_WAIT);
  assign w_clr = (r_state == S_LAUNCH) || (r_state == S_ADVANCE);

  done_collector #(.NUM_UNITS(NUM_UNITS)) u_collector (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .clr       (w_clr),
    .en        (w_en),
    .unit_done (bus.unit_done),
    .all_done  (w_all_done)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.unit_start  = 1'b0;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    bus.timeout_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.unit_start = 1'b1;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over an expiring watchdog in the same cycle.
        if (w_all_done)                w_state_nxt = S_ADVANCE;
        else if (r_wd_cnt == CNT_LAST) w_state_nxt = S_ERROR;
      end
      S_ADVANCE: begin
        w_state_nxt = (r_layer_idx == LAYER_LAST) ? S_FINISH : S_LAUNCH;
      end
      S_FINISH: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        bus.busy        = 1'b0;
        bus.timeout_err = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_layer_idx <= '0;
      r_wd_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE:    if (bus.start) r_layer_idx <= '0;
        S_LAUNCH:  r_wd_cnt <= '0;
        S_WAIT:    if (!w_all_done && (r_wd_cnt != CNT_LAST))
                     r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        S_ADVANCE: if (r_layer_idx != LAYER_LAST)
                     r_layer_idx <= r_layer_idx + LIDX_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.layer_idx = r_layer_idx;

endmodule

// File: tb/tb_layer_done_sequencer.sv
// tb_layer_done_sequencer
//   Drives two sequencers (default watchdog and an 8-cycle watchdog) with
//   identical stimulus and checks every output, every cycle, against a
//   schedule predicted from the layer/watchdog rules.
module tb_layer_done_sequencer;
  localparam int NU   = 4;
  localparam int NL   = 3;
  localparam int MAXC = 80;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  layer_done_sequencer_if #(.NUM_UNITS(NU), .LIDX_W(2)) if0 ();
  layer_done_sequencer_if #(.NUM_UNITS(NU), .LIDX_W(2)) if1 ();

  layer_done_sequencer #(.NUM_UNITS(NU), .NUM_LAYERS(NL), .TIMEOUT(1024)) u_def (
    .CLOCK(CLOCK), .RESET(RESET), .bus(if0.slave));
  layer_done_sequencer #(.NUM_UNITS(NU), .NUM_LAYERS(NL), .TIMEOUT(8)) u_t8 (
    .CLOCK(CLOCK), .RESET(RESET), .bus(if1.slave));

  // stimulus per cycle: applied during cycle c, sampled at the edge ending it
  bit          st [MAXC];
  bit          rs [MAXC];
  logic [3:0]  ud [MAXC];
  int          n_cyc;

  // expected outputs visible during cycle c, per DUT
  logic        e_us   [2][MAXC];
  logic [1:0]  e_li   [2][MAXC];
  logic        e_busy [2][MAXC];
  logic        e_done [2][MAXC];
  logic        e_err  [2][MAXC];

  int n_vec = 0;
  int n_err = 0;

  function automatic bit emit(int d, int k, logic us, int li, logic bz, logic dn, logic er);
    if (k >= n_cyc) return 1'b1;
    e_us[d][k] = us; e_li[d][k] = 2'(li); e_busy[d][k] = bz;
    e_done[d][k] = dn; e_err[d][k] = er;
    return rs[k];
  endfunction

  // Schedule model: walk the inference layer by layer, each layer lasting
  // launch + WAIT cycles until every unit has reported + advance.
  task automatic model(int d, int tmo);
    int k = 0;
    int lh = 0;
    int j;
    bit ab;
    logic [3:0] acc;
    while (k < n_cyc) begin
      ab = emit(d, k, 1'b0, lh, 1'b0, 1'b0, 1'b0);
      if (rs[k] || !st[k]) begin
        if (rs[k]) lh = 0;
        k++;
        continue;
      end
      k++;
      ab = 1'b0;
      for (int l = 0; l < NL && !ab; l++) begin
        ab = emit(d, k, 1'b1, l, 1'b1, 1'b0, 1'b0); k++;
        acc = '0; j = 0;
        while (!ab) begin
          j++;
          ab = emit(d, k, 1'b0, l, 1'b1, 1'b0, 1'b0);
          if (!ab) acc |= ud[k];
          k++;
          if (!ab && (&acc)) break;
          if (!ab && j == tmo)
            while (!ab) begin ab = emit(d, k, 1'b0, l, 1'b0, 1'b0, 1'b1); k++; end
        end
        if (!ab) begin ab = emit(d, k, 1'b0, l, 1'b1, 1'b0, 1'b0); k++; end
      end
      if (!ab) begin
        ab = emit(d, k, 1'b0, NL-1, 1'b1, 1'b1, 1'b0); k++;
        lh = ab ? 0 : NL-1;
      end else begin
        lh = 0;
      end
    end
  endtask

  task automatic chk(string tag, int d, int c, logic [3:0] obs, logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cycle %0d observed=%0h expected=%0h", tag, d, c, obs, exp);
    end
  endtask

  task automatic chk_dut(int d, int c, logic us, logic [1:0] li, logic bz, logic dn, logic er);
    chk("unit_start",  d, c, {3'b0, us}, {3'b0, e_us[d][c]});
    chk("layer_idx",   d, c, {2'b0, li}, {2'b0, e_li[d][c]});
    chk("busy",        d, c, {3'b0, bz}, {3'b0, e_busy[d][c]});
    chk("done",        d, c, {3'b0, dn}, {3'b0, e_done[d][c]});
    chk("timeout_err", d, c, {3'b0, er}, {3'b0, e_err[d][c]});
  endtask

  task automatic drive(logic s, logic [3:0] u, logic r);
    if0.start = s; if1.start = s;
    if0.unit_done = u; if1.unit_done = u;
    RESET = r;
  endtask

  task automatic clr_stim(int n);
    n_cyc = n;
    for (int c = 0; c < MAXC; c++) begin st[c] = 1'b0; rs[c] = 1'b0; ud[c] = 4'h0; end
  endtask

  task automatic run();
    model(0, 1024);
    model(1, 8);
    drive(1'b0, 4'h0, 1'b1);
    @(posedge CLOCK); #1;
    for (int c = 0; c < n_cyc; c++) begin
      chk_dut(0, c, if0.unit_start, if0.layer_idx, if0.busy, if0.done, if0.timeout_err);
      chk_dut(1, c, if1.unit_start, if1.layer_idx, if1.busy, if1.done, if1.timeout_err);
      drive(st[c], ud[c], rs[c]);
      @(posedge CLOCK); #1;
    end
    drive(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 4'h0, 1'b1);
    repeat (2) @(posedge CLOCK);
    #1;

    // all units done on WAIT cycle 1 of every layer: done at cycle 10
    clr_stim(16); st[0] = 1'b1; ud[2] = 4'hF; ud[5] = 4'hF; ud[8] = 4'hF;
    run();

    // staggered single pulses on WAIT cycles 1,4,2,7
    clr_stim(24); st[0] = 1'b1;
    ud[2] = 4'h1; ud[5] = 4'h2; ud[3] = 4'h4; ud[8] = 4'h8;
    for (int c = 10; c < 24; c++) ud[c] = 4'hF;
    run();

    // unit 3 never done: 8-cycle watchdog traps, starts ignored, reset clears
    clr_stim(34); st[0] = 1'b1; st[15] = 1'b1; st[20] = 1'b1; rs[30] = 1'b1;
    for (int c = 0; c < 30; c++) ud[c] = 4'h7;
    run();

    // last unit arrives on the watchdog's final WAIT cycle
    clr_stim(24); st[0] = 1'b1;
    for (int c = 2; c < 9; c++) ud[c] = 4'h7;
    for (int c = 9; c < 24; c++) ud[c] = 4'hF;
    run();

    // reset during WAIT of layer 1, then a clean inference
    clr_stim(24); st[0] = 1'b1; ud[2] = 4'hF; rs[6] = 1'b1; st[9] = 1'b1;
    for (int c = 10; c < 24; c++) ud[c] = 4'hF;
    run();

    // start held high; unit 3 pulses in LAUNCH of layer 1 (must be ignored)
    clr_stim(40);
    for (int c = 0; c < 40; c++) begin st[c] = 1'b1; ud[c] = (c >= 9) ? 4'hF : 4'h7; end
    ud[2] = 4'hF; ud[4] = 4'hF; ud[7] = 4'hF;
    run();

    // randomized traffic
    for (int s = 0; s < 6; s++) begin
      clr_stim(60);
      for (int c = 0; c < 60; c++) begin
        st[c] = (c == 0) || ($urandom_range(0, 9) == 0);
        rs[c] = ($urandom_range(0, 49) == 0);
        for (int u = 0; u < NU; u++) ud[c][u] = ($urandom_range(0, 2) == 0);
      end
      run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
